// File: rtl/fsm_bus_ctrl.sv
// fsm_bus_ctrl: asynchronous parallel-bus master for the shared FLASH/SRAM bus.
// Accepts one valid/ready request, runs a setup/strobe/hold/turnaround cycle
// with optional ready/busy stretching and timeout, and returns one response.
// All externally visible outputs are registered from the next-state values.
module fsm_bus_ctrl #(
    parameter int AW           = 26,
    parameter int DW           = 32,
    parameter int NCS          = 2,
    parameter int CSW          = 1,
    parameter int T_SETUP      = 2,
    parameter int T_ACCESS     = 8,
    parameter int T_HOLD       = 2,
    parameter int T_TURN       = 2,
    parameter int USE_WAIT     = 1,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [CSW-1:0] req_cs,
    input  logic [AW-1:0]  req_addr,
    input  logic [DW-1:0]  req_wdata,
    output logic           rsp_valid,
    output logic [DW-1:0]  rsp_rdata,
    output logic           rsp_err,
    output logic [AW-1:0]  bus_addr,
    output logic [DW-1:0]  bus_dq_o,
    output logic           bus_dq_oe,
    input  logic [DW-1:0]  bus_dq_i,
    output logic [NCS-1:0] bus_ce_n,
    output logic           bus_oe_n,
    output logic           bus_we_n,
    input  logic           bus_rdy_i
);

    localparam int TW = $clog2(WAIT_TIMEOUT + 1);
    localparam int CW = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_TURN   = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           write_q, write_d;
    logic [CSW-1:0] cs_q, cs_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           rdy_meta_q, rdy_s_q;
    logic           rdy_go_s;

    logic           req_ready_q, req_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;
    logic [NCS-1:0] ce_n_q, ce_n_d;
    logic           oe_n_q, oe_n_d;
    logic           we_n_q, we_n_d;
    logic           dq_oe_q, dq_oe_d;
    logic           active_s, strobe_s;

    // With stretching disabled the device is always treated as ready.
    assign rdy_go_s = (USE_WAIT == 0) || rdy_s_q;

    // Two-flop synchronizer for the asynchronous ready/busy pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
        end else begin
            rdy_meta_q <= bus_rdy_i;
            rdy_s_q    <= rdy_meta_q;
        end
    end

    // Transaction sequencer: phase counting, request latching, data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        write_d = write_q;
        cs_d    = cs_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d = req_write;
                    cs_d    = req_cs;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (int'(req_cs) < NCS) begin
                        state_d = S_SETUP;
                        err_d   = 1'b0;
                    end else begin
                        // Unknown chip select: no bus activity, straight to turnaround.
                        state_d = S_TURN;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(T_SETUP - 1)) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACCESS: begin
                if (cnt_q == CW'(T_ACCESS - 1)) begin
                    cnt_d = '0;
                    if (!rdy_go_s) begin
                        state_d = S_WAIT;
                        tmo_d   = '0;
                    end else begin
                        state_d = S_HOLD;
                        if (!write_q) begin
                            rdata_d = bus_dq_i;
                        end else begin
                            rdata_d = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (rdy_s_q) begin
                    state_d = S_HOLD;
                    if (!write_q) begin
                        rdata_d = bus_dq_i;
                    end else begin
                        rdata_d = '0;
                    end
                end else if (tmo_q == TW'(WAIT_TIMEOUT - 1)) begin
                    state_d = S_HOLD;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(T_HOLD - 1)) begin
                    state_d = S_TURN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TURN: begin
                if (cnt_q == CW'(T_TURN - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so every pin is a plain flop.
    always_comb begin
        active_s    = (state_d == S_SETUP) || (state_d == S_ACCESS) ||
                      (state_d == S_WAIT)  || (state_d == S_HOLD);
        strobe_s    = (state_d == S_ACCESS) || (state_d == S_WAIT);
        ce_n_d      = '1;
        for (int i = 0; i < NCS; i++) begin
            if (active_s && (int'(cs_d) == i)) begin
                ce_n_d[i] = 1'b0;
            end else begin
                ce_n_d[i] = 1'b1;
            end
        end
        oe_n_d      = !(strobe_s && !write_d);
        we_n_d      = !(strobe_s && write_d);
        dq_oe_d     = active_s && write_d;
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_TURN) && (state_q != S_TURN);
        if (rsp_valid_d) begin
            rsp_rdata_d = rdata_d;
            rsp_err_d   = err_d;
        end else begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
        end
    end

    // State, latched request and registered outputs; reset releases the bus at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            write_q     <= 1'b0;
            cs_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            ce_n_q      <= '1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            write_q     <= write_d;
            cs_q        <= cs_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign bus_addr  = addr_q;
    assign bus_dq_o  = wdata_q;
    assign bus_dq_oe = dq_oe_q;
    assign bus_ce_n  = ce_n_q;
    assign bus_oe_n  = oe_n_q;
    assign bus_we_n  = we_n_q;

endmodule

// File: tb/tb_fsm_bus_ctrl.sv
// Testbench for fsm_bus_ctrl: table-driven transactions with cycle-exact
// pin expectations, plus wait-stretch, timeout, back-to-back and reset cases.
module tb_fsm_bus_ctrl;

    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int NCS = 3;
    localparam int CSW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid, req_ready, req_write;
    logic [CSW-1:0] req_cs;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic           rsp_valid, rsp_err;
    logic [DW-1:0]  rsp_rdata;
    logic [AW-1:0]  bus_addr;
    logic [DW-1:0]  bus_dq_o, bus_dq_i;
    logic           bus_dq_oe, bus_oe_n, bus_we_n, bus_rdy_i;
    logic [NCS-1:0] bus_ce_n;

    always #5 clk = ~clk;

    fsm_bus_ctrl #(
        .AW(AW), .DW(DW), .NCS(NCS), .CSW(CSW), .WAIT_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_cs(req_cs), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_addr(bus_addr), .bus_dq_o(bus_dq_o), .bus_dq_oe(bus_dq_oe),
        .bus_dq_i(bus_dq_i), .bus_ce_n(bus_ce_n), .bus_oe_n(bus_oe_n),
        .bus_we_n(bus_we_n), .bus_rdy_i(bus_rdy_i)
    );

    typedef struct {
        logic           wr;
        logic [CSW-1:0] cs;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [DW-1:0]  dq;
        logic [DW-1:0]  exp_rdata;
        logic           exp_err;
    } vec_t;

    vec_t vecs[7];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Present a request at a negedge, wait for ready, return at the first sample after the handshake.
    task automatic issue(input vec_t v, input logic keep_valid);
        int n;
        req_valid = 1'b1;
        req_write = v.wr;
        req_cs    = v.cs;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        bus_dq_i  = v.dq;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n < 40), 64'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid = keep_valid;
    endtask

    // Run one transaction; strobe ends at sample oe_last (10 unless stretched),
    // rdy/dq change at sample raise_k (0 = never).
    task automatic run_seq(input vec_t v, input string tag, input int oe_last,
                           input int raise_k, input logic [DW-1:0] new_dq);
        logic           inv, act, strb;
        int             rk, last;
        logic [NCS-1:0] ce_exp;
        inv  = (int'(v.cs) >= NCS);
        rk   = inv ? 1 : oe_last + 3;
        last = inv ? 3 : oe_last + 5;
        issue(v, 1'b0);
        for (int k = 1; k <= last; k++) begin
            act    = !inv && (k <= oe_last + 2);
            strb   = !inv && (k >= 3) && (k <= oe_last);
            ce_exp = act ? ~(NCS'(1) << v.cs) : '1;
            chk({tag, " ce_n"},      64'(bus_ce_n),  64'(ce_exp));
            chk({tag, " oe_n"},      64'(bus_oe_n),  64'(!(strb && !v.wr)));
            chk({tag, " we_n"},      64'(bus_we_n),  64'(!(strb && v.wr)));
            chk({tag, " dq_oe"},     64'(bus_dq_oe), 64'(act && v.wr));
            chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(k == rk));
            chk({tag, " req_ready"}, 64'(req_ready), 64'(k == last));
            if (k == rk) begin
                chk({tag, " rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
                chk({tag, " err"},   64'(rsp_err),   64'(v.exp_err));
            end
            if (act) begin
                chk({tag, " addr"}, 64'(bus_addr), 64'(v.addr));
            end
            if (act && v.wr) begin
                chk({tag, " dq_o"}, 64'(bus_dq_o), 64'(v.wdata));
            end
            if (k == raise_k) begin
                bus_rdy_i = 1'b1;
                bus_dq_i  = new_dq;
            end
            if (k < last) begin
                @(negedge clk);
            end
        end
    endtask

    vec_t sv;
    int   acc[8];
    int   nacc, rsp_cnt, n;

    initial begin
        vecs[0] = '{1'b0, 2'd0, 26'h0001234, 32'h0,        32'hA5A55A5A, 32'hA5A55A5A, 1'b0};
        vecs[1] = '{1'b1, 2'd1, 26'h0000100, 32'hDEADBEEF, 32'h11111111, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 2'd2, 26'h3FFFFFF, 32'h0,        32'h12345678, 32'h12345678, 1'b0};
        vecs[3] = '{1'b1, 2'd0, 26'h0000000, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0};
        vecs[4] = '{1'b0, 2'd3, 26'h0000055, 32'h0,        32'hCAFEF00D, 32'h0,        1'b1};
        vecs[5] = '{1'b1, 2'd3, 26'h0000066, 32'h87654321, 32'h0,        32'h0,        1'b1};
        vecs[6] = '{1'b0, 2'd1, 26'h2AAAAAA, 32'h0,        32'h00000000, 32'h0,        1'b0};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_cs = '0;
        req_addr = '0; req_wdata = '0; bus_dq_i = '0; bus_rdy_i = 1'b1;

        // Reset values and first ready edge.
        repeat (3) @(negedge clk);
        chk("rst ce_n",  64'(bus_ce_n),  64'(3'b111));
        chk("rst oe_n",  64'(bus_oe_n),  64'(1));
        chk("rst we_n",  64'(bus_we_n),  64'(1));
        chk("rst dq_oe", 64'(bus_dq_oe), 64'(0));
        chk("rst addr",  64'(bus_addr),  64'(0));
        chk("rst dq_o",  64'(bus_dq_o),  64'(0));
        chk("rst rsp",   64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        chk("rst ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        chk("ready before edge", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("ready after edge", 64'(req_ready), 64'(1));

        // Table of straight transactions with the device always ready.
        for (int i = 0; i < 7; i++) begin
            run_seq(vecs[i], $sformatf("vec%0d", i), 10, 0, '0);
        end

        // Stretch: rdy low, released at sample 22; data captured from the post-release value.
        bus_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        sv = '{1'b0, 2'd0, 26'h0000ABC, 32'h0, 32'hBAD0BAD0, 32'h13579BDF, 1'b0};
        run_seq(sv, "stretch", 24, 22, 32'h13579BDF);

        // Timeout: rdy stuck low for exactly 16 wait cycles.
        bus_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        sv = '{1'b0, 2'd1, 26'h0000321, 32'h0, 32'hFFFF0000, 32'h0, 1'b1};
        run_seq(sv, "timeout", 26, 0, '0);
        bus_rdy_i = 1'b1;
        run_seq(vecs[0], "after_timeout", 10, 0, '0);

        // Back-to-back reads with req_valid held high.
        sv = '{1'b0, 2'd2, 26'h0000077, 32'h0, 32'h24681357, 32'h24681357, 1'b0};
        req_valid = 1'b1; req_write = sv.wr; req_cs = sv.cs;
        req_addr = sv.addr; bus_dq_i = sv.dq;
        nacc = 0; rsp_cnt = 0;
        for (int s = 0; s < 47; s++) begin
            if (req_ready === 1'b1 && nacc < 8) begin
                acc[nacc] = s;
                nacc++;
            end
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                chk("b2b rdata", 64'(rsp_rdata), 64'(32'h24681357));
            end
            chk("b2b one ce", 64'($countones(~bus_ce_n) <= 1), 64'(1));
            chk("b2b no oe+we", 64'(bus_oe_n | bus_we_n), 64'(1));
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b accepts", 64'(nacc), 64'(4));
        chk("b2b rsp count", 64'(rsp_cnt), 64'(3));
        for (int i = 0; i < 3; i++) begin
            if (i + 1 < nacc) begin
                chk("b2b spacing", 64'(acc[i+1] - acc[i]), 64'(15));
            end
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b drain", 64'(n < 40), 64'(1));

        // Reset during the strobe of a write: bus released at once, no response.
        issue(vecs[1], 1'b0);
        repeat (4) @(negedge clk);
        chk("pre-rst we_n", 64'(bus_we_n), 64'(0));
        #1 rst = 1'b1;
        #1;
        chk("mid-rst ce_n",  64'(bus_ce_n),  64'(3'b111));
        chk("mid-rst we_n",  64'(bus_we_n),  64'(1));
        chk("mid-rst oe_n",  64'(bus_oe_n),  64'(1));
        chk("mid-rst dq_oe", 64'(bus_dq_oe), 64'(0));
        chk("mid-rst ready", 64'(req_ready), 64'(0));
        rsp_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("post-rst ready0", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("post-rst ready1", 64'(req_ready), 64'(1));
        for (int s = 0; s < 20; s++) begin
            if (rsp_valid === 1'b1) rsp_cnt++;
            @(negedge clk);
        end
        chk("post-rst no rsp", 64'(rsp_cnt), 64'(0));
        run_seq(vecs[2], "after_rst", 10, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
